// File: rtl/rotary_encoder.sv
// rtl/rotary_encoder.sv - quadrature rotary-encoder front end driving a saturating DDS frequency-table address
//
// Ports:
//   Fg_CLK   in   1  system clock
//   RESETn   in   1  asynchronous active-low reset
//   Rot_A    in   1  encoder phase A (asynchronous, idles high)
//   Rot_B    in   1  encoder phase B (asynchronous, idles high)
//   Rot_C    in   1  push-button, active high (asynchronous, may be one clock wide)
//   Address  out 11  frequency-table address, registered
//   FreqChng out  1  one-cycle pulse in the cycle Address takes a new value
module rotary_encoder #(
    parameter int DEBOUNCE_LEN = 16,
    parameter int ADDR_MAX     = 2047
) (
    input  logic        Fg_CLK,
    input  logic        RESETn,
    input  logic        Rot_A,
    input  logic        Rot_B,
    input  logic        Rot_C,
    output logic [10:0] Address,
    output logic        FreqChng
);

    localparam int          CW     = $clog2(DEBOUNCE_LEN + 1);
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(DEBOUNCE_LEN - 1);
    localparam logic [11:0] LP_MAX = 12'(ADDR_MAX);

    // 2-FF synchronisers
    logic r_a_meta, r_a_sync;
    logic r_b_meta, r_b_sync;
    logic r_c_meta, r_c_sync, r_c_sync_d;

    // debounce state
    logic          r_a_deb, r_a_deb_d, r_b_deb;
    logic [CW-1:0] r_a_cnt, r_b_cnt;

    logic [1:0]  r_step_idx;
    logic [10:0] r_addr;
    logic        r_freq_chng;

    logic        w_press;
    logic        w_a_fall;
    logic [11:0] w_step;
    logic [11:0] w_cur;
    logic [11:0] w_sum;
    logic [11:0] w_inc_val;
    logic [11:0] w_dec_val;
    logic [11:0] w_next;
    logic        w_changed;

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_a_meta   <= 1'b1;
            r_a_sync   <= 1'b1;
            r_b_meta   <= 1'b1;
            r_b_sync   <= 1'b1;
            r_c_meta   <= 1'b0;
            r_c_sync   <= 1'b0;
            r_c_sync_d <= 1'b0;
        end else begin
            r_a_meta   <= Rot_A;
            r_a_sync   <= r_a_meta;
            r_b_meta   <= Rot_B;
            r_b_sync   <= r_b_meta;
            r_c_meta   <= Rot_C;
            r_c_sync   <= r_c_meta;
            r_c_sync_d <= r_c_sync;
        end
    end

    // A level is accepted on the DEBOUNCE_LEN-th consecutive differing sample;
    // any sample matching the current level restarts the count.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_a_deb   <= 1'b1;
            r_a_deb_d <= 1'b1;
            r_a_cnt   <= '0;
        end else begin
            r_a_deb_d <= r_a_deb;
            if (r_a_sync == r_a_deb) begin
                r_a_cnt <= '0;
            end else if (r_a_cnt == LP_CNT_LAST) begin
                r_a_deb <= r_a_sync;
                r_a_cnt <= '0;
            end else begin
                r_a_cnt <= r_a_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_b_deb <= 1'b1;
            r_b_cnt <= '0;
        end else begin
            if (r_b_sync == r_b_deb) begin
                r_b_cnt <= '0;
            end else if (r_b_cnt == LP_CNT_LAST) begin
                r_b_deb <= r_b_sync;
                r_b_cnt <= '0;
            end else begin
                r_b_cnt <= r_b_cnt + 1'b1;
            end
        end
    end

    assign w_press  = r_c_sync & ~r_c_sync_d;
    assign w_a_fall = r_a_deb_d & ~r_a_deb;

    always_comb begin
        w_step = 12'd1;
        case (r_step_idx)
            2'd0:    w_step = 12'd1;
            2'd1:    w_step = 12'd10;
            2'd2:    w_step = 12'd100;
            default: w_step = 12'd1000;
        endcase
    end

    // B still high at A's falling edge means A leads: decrement.
    assign w_cur     = {1'b0, r_addr};
    assign w_sum     = w_cur + w_step;
    assign w_inc_val = (w_sum > LP_MAX) ? LP_MAX : w_sum;
    assign w_dec_val = (w_cur < w_step) ? 12'd0 : (w_cur - w_step);
    assign w_next    = r_b_deb ? w_dec_val : w_inc_val;
    assign w_changed = w_a_fall && (w_next[10:0] != r_addr);

    // The step in a press cycle uses the old index since both read r_step_idx.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_step_idx  <= 2'd0;
            r_addr      <= 11'd0;
            r_freq_chng <= 1'b0;
        end else begin
            if (w_press) begin
                r_step_idx <= r_step_idx + 2'd1;
            end
            if (w_changed) begin
                r_addr <= w_next[10:0];
            end
            r_freq_chng <= w_changed;
        end
    end

    assign Address  = r_addr;
    assign FreqChng = r_freq_chng;

endmodule

// File: tb/tb_rotary_encoder.sv
// tb/tb_rotary_encoder.sv - directed self-checking bench for rotary_encoder
module tb_rotary_encoder;

    logic        Fg_CLK;
    logic        RESETn;
    logic        Rot_A;
    logic        Rot_B;
    logic        Rot_C;
    logic [10:0] Address;
    logic        FreqChng;

    int n_cmp;
    int n_err;
    int pulses;
    int run_len;
    int max_run;
    int p0;
    int lat;

    rotary_encoder #(
        .DEBOUNCE_LEN(16),
        .ADDR_MAX    (2047)
    ) dut (
        .Fg_CLK  (Fg_CLK),
        .RESETn  (RESETn),
        .Rot_A   (Rot_A),
        .Rot_B   (Rot_B),
        .Rot_C   (Rot_C),
        .Address (Address),
        .FreqChng(FreqChng)
    );

    initial Fg_CLK = 1'b0;
    always #5 Fg_CLK = ~Fg_CLK;

    // FreqChng pulse count and longest run, sampled away from the active edge
    always @(negedge Fg_CLK) begin
        if (FreqChng === 1'b1) begin
            pulses  = pulses + 1;
            run_len = run_len + 1;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge Fg_CLK);
    endtask

    task automatic inc_detent();
        Rot_B = 1'b0; hold(100);
        Rot_A = 1'b0; hold(100);
        Rot_B = 1'b1; hold(100);
        Rot_A = 1'b1; hold(100);
    endtask

    task automatic dec_detent();
        Rot_A = 1'b0; hold(100);
        Rot_B = 1'b0; hold(100);
        Rot_A = 1'b1; hold(100);
        Rot_B = 1'b1; hold(100);
    endtask

    task automatic press();
        Rot_C = 1'b1; hold(1);
        Rot_C = 1'b0; hold(10);
    endtask

    task automatic do_reset();
        Rot_A  = 1'b1;
        Rot_B  = 1'b1;
        Rot_C  = 1'b0;
        RESETn = 1'b0;
        hold(10);
        RESETn = 1'b1;
        hold(10);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        pulses  = 0;
        run_len = 0;
        max_run = 0;
        Rot_A   = 1'b1;
        Rot_B   = 1'b1;
        Rot_C   = 1'b0;
        RESETn  = 1'b0;
        hold(100);
        check("reset_addr", 32'(Address), 32'd0);
        check("reset_fc", 32'(FreqChng), 32'd0);
        RESETn = 1'b1;
        hold(10);

        // lower clamp
        dec_detent();
        dec_detent();
        check("clamp0_addr", 32'(Address), 32'd0);
        check("clamp0_pulses", 32'(pulses), 32'd0);

        // increment by 1 with latency measurement
        p0 = pulses;
        Rot_B = 1'b0; hold(100);
        Rot_A = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Fg_CLK);
            if (lat < 0 && Address == 11'd1) lat = i;
        end
        check("inc1_latency", 32'(lat), 32'd19);
        hold(60);
        Rot_B = 1'b1; hold(100);
        Rot_A = 1'b1; hold(100);
        check("inc1_addr", 32'(Address), 32'd1);
        check("inc1_pulses", 32'(pulses - p0), 32'd1);

        // step-size cycling
        p0 = pulses;
        press();
        check("press1_addr", 32'(Address), 32'd1);
        check("press1_pulses", 32'(pulses - p0), 32'd0);
        inc_detent();
        check("step10_addr", 32'(Address), 32'd11);
        p0 = pulses;
        press();
        check("press2_addr", 32'(Address), 32'd11);
        check("press2_pulses", 32'(pulses - p0), 32'd0);
        inc_detent();
        check("step100_addr", 32'(Address), 32'd111);
        dec_detent();
        check("dec100_addr", 32'(Address), 32'd11);

        // step index wrap
        do_reset();
        check("rst2_addr", 32'(Address), 32'd0);
        repeat (4) press();
        inc_detent();
        check("wrap_addr", 32'(Address), 32'd1);

        // upper saturation with step 1000
        do_reset();
        repeat (3) press();
        inc_detent();
        check("sat1_addr", 32'(Address), 32'd1000);
        inc_detent();
        check("sat2_addr", 32'(Address), 32'd2000);
        p0 = pulses;
        inc_detent();
        check("sat3_addr", 32'(Address), 32'd2047);
        check("sat3_pulses", 32'(pulses - p0), 32'd1);
        p0 = pulses;
        inc_detent();
        check("sat4_addr", 32'(Address), 32'd2047);
        check("sat4_pulses", 32'(pulses - p0), 32'd0);

        // glitch rejection: 5-cycle A low would otherwise decrement
        p0 = pulses;
        Rot_A = 1'b0; hold(5);
        Rot_A = 1'b1; hold(50);
        check("glitch_addr", 32'(Address), 32'd2047);
        check("glitch_pulses", 32'(pulses - p0), 32'd0);

        // async reset mid-detent
        Rot_B = 1'b0; hold(100);
        Rot_A = 1'b0; hold(10);
        RESETn = 1'b0;
        #1;
        check("async_addr", 32'(Address), 32'd0);
        check("async_fc", 32'(FreqChng), 32'd0);
        Rot_A = 1'b1;
        Rot_B = 1'b1;
        hold(10);
        RESETn = 1'b1;
        hold(50);
        check("post_rst_addr", 32'(Address), 32'd0);
        inc_detent();
        check("post_rst_step1", 32'(Address), 32'd1);

        check("pulse_width", 32'(max_run), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
